// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one single-port OBI memory between the GPGPU
// instruction-fetch port and data port, with request locking and in-order response routing.
module obi_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    err_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  src_e             prio_q, prio_d;
  logic             lock_q, lock_d;
  src_e             lock_id_q, lock_id_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  src_e             id_fifo_q [MAX_OUTSTANDING];

  src_e sel;
  logic sel_req, full, empty, mem_req, hs, pop;
  src_e head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Selection: a refused request keeps the port until it is granted.
  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel = prio_q;
    if (lock_q)                          sel = lock_id_q;
    else if (instr_req_i && !data_req_i) sel = SRC_INSTR;
    else if (data_req_i && !instr_req_i) sel = SRC_DATA;
    sel_req = (sel == SRC_DATA) ? data_req_i : instr_req_i;
  end

  assign full    = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (cnt_q == '0);
  assign mem_req = sel_req && !full;
  assign hs      = mem_req && mem_gnt_i;
  assign pop     = mem_rvalid_i && !empty;
  assign head    = id_fifo_q[rd_ptr_q];

  // Everything is forced low while reset is held, including pass-through paths.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    instr_rdata_o  = '0;
    data_rdata_o   = '0;
    if (rst_ni) begin
      mem_req_o = mem_req;
      if (sel == SRC_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o   = {BE_W{1'b1}};
        mem_addr_o = instr_addr_i;
      end
      instr_gnt_o    = hs && (sel == SRC_INSTR);
      data_gnt_o     = hs && (sel == SRC_DATA);
      instr_rvalid_o = pop && (head == SRC_INSTR);
      data_rvalid_o  = pop && (head == SRC_DATA);
      instr_rdata_o  = mem_rdata_i;
      data_rdata_o   = mem_rdata_i;
    end
  end

  assign err_o = err_q;

  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (hs) begin
      prio_d   = (sel == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
      lock_d   = 1'b0;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else if (mem_req) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end

    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (mem_rvalid_i && empty) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= SRC_DATA;
      lock_q    <= 1'b0;
      lock_id_q <= SRC_INSTR;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the ID storage has no reset; entries are only read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (hs) id_fifo_q[wr_ptr_q] <= sel;
  end

endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one single-port OBI memory port between the GPGPU instruction-fetch OBI port and data OBI port.
- Sits between gpgpu_top and a single-port RAM. Replaces the dual-port RAM arrangement when only one physical port is available.
- Round-robin arbitration with request locking.
- Tracks in-order outstanding transactions and routes each response back to the requester that issued it.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions; power of two, ≥1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- instr_req_i  in  1  instruction request
- instr_addr_i  in  ADDR_WIDTH  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  DATA_WIDTH  instruction read data
- data_req_i  in  1  data request
- data_we_i  in  1  data write enable
- data_be_i  in  DATA_WIDTH/8  data byte enables
- data_addr_i  in  ADDR_WIDTH  data address
- data_wdata_i  in  DATA_WIDTH  data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  DATA_WIDTH  data read data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_WIDTH  memory read data
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync release) clears the following state:
  - ID FIFO empty; outstanding count 0.
  - Priority pointer = DATA.
  - Lock cleared.
  - err_o = 0.
- Outputs during reset: all gnt/rvalid/mem_req_o = 0; data/addr outputs 0.
- Reset mid-operation drops all in-flight responses. Any mem_rvalid_i after reset with an empty FIFO sets err_o.
- Selection (combinational):
  - If the lock is set, select the locked requester.
  - Else if only one requester is asserting req, select it.
  - Else if both are asserting req, select the priority-pointer owner.
- full = (count == MAX_OUTSTANDING).
- mem_req_o = selected requester's req AND NOT full.
- Mux to the memory port:
  - Instruction selected: mem_we_o = 0, mem_be_o = all ones, mem_wdata_o = 0.
  - Data selected: data fields passed through.
- Grant: selected_gnt_o = mem_gnt_i AND mem_req_o. Non-selected gnt = 0. Zero-cycle grant path.
- Handshake: mem_req_o AND mem_gnt_i.
  - Push selected ID (0 = instr, 1 = data) into the ID FIFO.
  - Priority pointer moves to the non-granted requester.
  - Lock clears.
- Lock: mem_req_o high AND mem_gnt_i low sets the lock to the selected requester. Selection stays stable until its handshake, per the OBI rule that requests are held.
- full blocks new requests but never blocks a pending lock's stability. mem_req_o drops only because of full, never switches owner.
- Response:
  - mem_rvalid_i pops the FIFO head.
  - The head ID's rvalid_o = 1 in the same cycle (combinational).
  - mem_rdata_i is driven to both rdata outputs unconditionally.
- Ordering: the memory returns responses in order, at least 1 cycle after grant. Push and pop in the same cycle: count unchanged.
- Full with a simultaneous pop: push is still blocked that cycle (grant depends on registered count only).
- mem_rvalid_i with empty FIFO: no requester rvalid; err_o set, sticky until reset.
- Count width: $clog2(MAX_OUTSTANDING+1). FIFO pointers wrap modulo MAX_OUTSTANDING.

Test Plan:
1. Only instr_req_i=1, addr 0x10, mem_gnt_i=1; next cycle mem_rvalid_i=1, rdata 0xDEADBEEF -> instr_gnt_o=1 in cycle 0, mem_addr_o=0x10, mem_we_o=0, mem_be_o=0xF; cycle 1 instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF, data_rvalid_o=0.
2. Both requesters held, mem_gnt_i=1 each cycle, one-cycle rvalid -> grant order DATA, INSTR, DATA, INSTR after reset; each response rvalid lands on the matching requester.
3. Data write (addr 0x40, be 0x3, wdata 0x1234) with mem_gnt_i=0 for 3 cycles, instr_req_i rising in cycle 1 -> mem_addr_o=0x40 for all 4 cycles, data granted in cycle 3, instr granted in cycle 4.
4. MAX_OUTSTANDING=4, continuous instr requests, mem_gnt_i=1, no rvalid -> 4 grants, then mem_req_o=0. One mem_rvalid_i -> instr_rvalid_o=1, next grant one cycle later.
5. mem_rvalid_i pulse with nothing outstanding -> err_o=1 from next cycle and held; no requester rvalid.
6. rst_ni asserted with 2 outstanding -> all outputs 0 immediately. After release, a stray mem_rvalid_i sets err_o, and a new instr request is granted normally with DATA priority restored.
